// File: rtl/wrapper_arb_pkg.sv
// Shared types for the hash-core wrapper arbiter: FSM state encoding and requester limit.
package wrapper_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT_D = 2'd2,
    RETURN = 2'd3
  } state_e;

endpackage

// File: rtl/wrapper_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant_i and wraps around.
module wrapper_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_req_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant_oh_o = '0;
    grant_o    = '0;
    sum        = '0;
    idx        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum = {1'b0, last_grant_i} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (req_i[idx]) begin
        grant_oh_o      = '0;
        grant_oh_o[idx] = 1'b1;
        grant_o         = idx;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/wrapper_hash_arbiter.sv
// Shares one hash core among NUM_REQ block streams; the grant is held per message until
// the tagged digest has been handed back to the requesters.
module wrapper_hash_arbiter
  import wrapper_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 512,
  parameter  int DIGEST_W = 256,
  parameter  int CNT_W    = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] s_tdata_i,
  input  logic [NUM_REQ-1:0]        s_tlast_i,
  input  logic [NUM_REQ-1:0]        s_tvalid_i,
  output logic [NUM_REQ-1:0]        s_tready_o,
  output logic [DATA_W-1:0]         m_tdata_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic [ID_W-1:0]           m_tid_o,
  input  logic [DIGEST_W-1:0]       d_tdata_i,
  input  logic                      d_tvalid_i,
  output logic                      d_tready_o,
  output logic [DIGEST_W-1:0]       r_tdata_o,
  output logic [ID_W-1:0]           r_tid_o,
  output logic                      r_tvalid_o,
  input  logic                      r_tready_i,
  output logic [CNT_W-1:0]          blk_cnt_o,
  output logic                      busy_o
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      grant_q, last_grant_q, arb_grant;
  logic [NUM_REQ-1:0]   grant_oh_q, arb_oh;
  logic                 any_req;
  logic [CNT_W-1:0]     blk_cnt_q;
  logic [DIGEST_W-1:0]  ret_data_q;
  logic [ID_W-1:0]      ret_id_q;
  logic                 blk_acc, d_acc, grant_latch;
  logic [DATA_W-1:0]    blk [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_blk
    assign blk[k] = s_tdata_i[k*DATA_W +: DATA_W];
  end

  wrapper_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (s_tvalid_i),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (arb_oh),
    .grant_o      (arb_grant),
    .any_req_o    (any_req)
  );

  assign grant_latch = (state_q == IDLE) && any_req;

  always_comb begin
    state_d    = state_q;
    m_tvalid_o = 1'b0;
    m_tdata_o  = '0;
    m_tlast_o  = 1'b0;
    m_tid_o    = '0;
    s_tready_o = '0;
    d_tready_o = 1'b0;
    r_tvalid_o = 1'b0;
    blk_acc    = 1'b0;
    d_acc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = STREAM;
      end
      STREAM: begin
        // Lock to the owner even while it idles; other requesters never see ready.
        m_tvalid_o = s_tvalid_i[grant_q];
        m_tdata_o  = blk[grant_q];
        m_tlast_o  = s_tlast_i[grant_q];
        m_tid_o    = grant_q;
        s_tready_o = grant_oh_q & {NUM_REQ{m_tready_i}};
        blk_acc    = s_tvalid_i[grant_q] & m_tready_i;
        if (blk_acc && s_tlast_i[grant_q]) state_d = WAIT_D;
      end
      WAIT_D: begin
        d_tready_o = 1'b1;
        if (d_tvalid_i) begin
          d_acc   = 1'b1;
          state_d = RETURN;
        end
      end
      RETURN: begin
        r_tvalid_o = 1'b1;
        if (r_tready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      blk_cnt_q    <= '0;
      ret_data_q   <= '0;
      ret_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_latch) begin
        grant_q      <= arb_grant;
        grant_oh_q   <= arb_oh;
        last_grant_q <= arb_grant;
        blk_cnt_q    <= '0;
      end else if (blk_acc && (blk_cnt_q != {CNT_W{1'b1}})) begin
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
      end
      if (d_acc) begin
        ret_data_q <= d_tdata_i;
        ret_id_q   <= grant_q;
      end
    end
  end

  assign r_tdata_o = ret_data_q;
  assign r_tid_o   = ret_id_q;
  assign blk_cnt_o = blk_cnt_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_wrapper_hash_arbiter.sv
// Bench for wrapper_hash_arbiter: cycle-level reference model of the per-message grant protocol.
module tb_wrapper_hash_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int GW = 256;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast, m_tvalid, m_tready;
  logic [IW-1:0]   m_tid;
  logic [GW-1:0]   d_tdata;
  logic            d_tvalid, d_tready;
  logic [GW-1:0]   r_tdata;
  logic [IW-1:0]   r_tid;
  logic            r_tvalid, r_tready;
  logic [CW-1:0]   blk_cnt;
  logic            busy;

  wrapper_hash_arbiter dut (
    .clk(clk), .rst(rst),
    .s_tdata_i(s_tdata), .s_tlast_i(s_tlast), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tlast_o(m_tlast), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tid_o(m_tid),
    .d_tdata_i(d_tdata), .d_tvalid_i(d_tvalid), .d_tready_o(d_tready),
    .r_tdata_o(r_tdata), .r_tid_o(r_tid), .r_tvalid_o(r_tvalid), .r_tready_i(r_tready),
    .blk_cnt_o(blk_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester sources and environment knobs
  logic [DW-1:0] srcq [N][$];
  bit            srcl [N][$];
  logic [DW-1:0] sent [$];
  int            gap_pct = 0, core_pct = 0, r_pct = 0, core_stall = 0, dig_dly_max = 0;
  bit            r_block = 0;
  bit            dig_pend = 0;
  int            dig_delay = 0;
  logic [GW-1:0] dig_val = '0;
  bit            dig_force_en = 0;
  logic [GW-1:0] dig_force = '0;

  // Reference model: phase 0 none, 1 streaming, 2 awaiting digest, 3 returning
  int            md_stage = 0, md_owner = -1, md_last = N-1, md_cnt = 0;
  logic [GW-1:0] md_dig = '0;

  // Observation logs (4-state so a missing entry never matches)
  logic [7:0]    glog [$];
  logic [7:0]    rlog [$];
  logic [GW-1:0] rdlog [$];
  logic [CW-1:0] rclog [$];
  logic [DW-1:0] mlog [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_blk();
    logic [DW-1:0] b;
    for (int i = 0; i < DW/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) if (req[(last+i)%N]) return (last+i)%N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (srcq[k].size() != 0) return 0;
    return 1;
  endfunction

  task automatic push_msg(input int k, input int len);
    logic [DW-1:0] b;
    for (int j = 0; j < len; j++) begin
      b = rand_blk();
      srcq[k].push_back(b);
      srcl[k].push_back(j == len-1);
      sent.push_back(b);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() != 0 && !($urandom_range(99) < gap_pct)) begin
        s_tvalid[k]            = 1'b1;
        s_tdata[k*DW +: DW]    = srcq[k][0];
        s_tlast[k]             = srcl[k][0];
      end else begin
        s_tvalid[k]            = 1'b0;
        s_tdata[k*DW +: DW]    = '0;
        s_tlast[k]             = 1'b0;
      end
    end
    m_tready = (core_stall == 0) && !($urandom_range(99) < core_pct);
    if (core_stall > 0) core_stall--;
    d_tvalid = dig_pend && (dig_delay == 0);
    if (dig_pend && dig_delay > 0) dig_delay--;
    d_tdata  = dig_val;
    r_tready = !r_block && !($urandom_range(99) < r_pct);
  endtask

  // One clock: check outputs at negedge, advance model at posedge, drive at posedge+1
  task automatic tick();
    bit acc, dacc, racc, lst;
    logic [N-1:0] exp_rdy;
    bit exp_mv;
    @(negedge clk);
    exp_rdy = '0;
    exp_mv  = 0;
    if (md_stage == 1) begin
      exp_rdy[md_owner] = m_tready;
      exp_mv            = s_tvalid[md_owner];
    end
    chk("busy", busy, md_stage != 0);
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, exp_mv);
    chk("d_tready", d_tready, md_stage == 2);
    chk("r_tvalid", r_tvalid, md_stage == 3);
    chk("blk_cnt", blk_cnt, md_cnt);
    if (md_stage == 1) begin
      chk("m_tid", m_tid, md_owner);
      chk("m_tdata", m_tdata, s_tdata[md_owner*DW +: DW]);
      chk("m_tlast", m_tlast, s_tlast[md_owner]);
    end
    if (md_stage == 3) begin
      chk("r_tdata", r_tdata, md_dig);
      chk("r_tid", r_tid, md_owner);
    end
    acc  = (md_stage == 1) && s_tvalid[md_owner] && m_tready;
    dacc = (md_stage == 2) && d_tvalid;
    racc = (md_stage == 3) && r_tready;
    if (acc) begin
      if (md_cnt == 0) glog.push_back(8'(m_tid));
      mlog.push_back(m_tdata);
    end
    if (racc) begin
      rlog.push_back(8'(r_tid));
      rdlog.push_back(r_tdata);
      rclog.push_back(blk_cnt);
    end
    @(posedge clk);
    case (md_stage)
      0: if (|s_tvalid) begin
        md_owner = rr_pick(s_tvalid, md_last);
        md_last  = md_owner;
        md_cnt   = 0;
        md_stage = 1;
      end
      1: if (acc) begin
        lst = srcl[md_owner][0];
        void'(srcq[md_owner].pop_front());
        void'(srcl[md_owner].pop_front());
        if (md_cnt < 65535) md_cnt++;
        if (lst) begin
          md_stage = 2;
          if (!dig_pend) begin
            dig_pend  = 1;
            dig_val   = dig_force_en ? dig_force : GW'(rand_blk());
            dig_delay = $urandom_range(dig_dly_max);
          end
        end
      end
      2: if (dacc) begin
        md_dig   = dig_val;
        dig_pend = 0;
        md_stage = 3;
      end
      3: if (racc) md_stage = 0;
      default: ;
    endcase
    #1 drive_inputs();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (!(md_stage == 0 && all_empty() && !dig_pend) && n < max) begin
      tick();
      n++;
    end
    tests++;
    assert (n < max) else begin
      fails++;
      $error("FAIL run_idle: cycles %0d limit %0d", n, max);
    end
  endtask

  task automatic wait_model(input int stage, input int cnt, input int max);
    int n = 0;
    while (!(md_stage == stage && md_cnt == cnt) && n < max) begin
      tick();
      n++;
    end
    tests++;
    assert (n < max) else begin
      fails++;
      $error("FAIL wait_model: stage %0d cnt %0d not reached", stage, cnt);
    end
  endtask

  task automatic clear_logs();
    glog.delete(); rlog.delete(); rdlog.delete(); rclog.delete(); mlog.delete(); sent.delete();
  endtask

  // Assert reset at posedge+1, confirm all outputs are zero, release after one edge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    dig_pend = 0;
    md_stage = 0; md_owner = -1; md_last = N-1; md_cnt = 0;
    drive_inputs();
    @(negedge clk);
    chk({tag, "_m_tdata"}, m_tdata, '0);
    chk({tag, "_m_tlast"}, m_tlast, 0);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_m_tid"}, m_tid, 0);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_d_tready"}, d_tready, 0);
    chk({tag, "_r_tdata"}, r_tdata, 0);
    chk({tag, "_r_tid"}, r_tid, 0);
    chk({tag, "_r_tvalid"}, r_tvalid, 0);
    chk({tag, "_blk_cnt"}, blk_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_inputs();
  endtask

  initial begin
    s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
    d_tdata = '0; d_tvalid = 1'b0; r_tready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 do_reset("rst0");

    // Single requester, three blocks, known digest
    clear_logs();
    dig_force_en = 1; dig_force = {8{32'hABCD_1234}};
    push_msg(0, 3);
    drive_inputs();
    run_idle(50);
    dig_force_en = 0;
    chk("t1_grant", glog[0], 0);
    chk("t1_rtid", rlog[0], 0);
    chk("t1_rdata", rdlog[0], {8{32'hABCD_1234}});
    chk("t1_cnt", rclog[0], 3);
    for (int i = 0; i < 3; i++) chk("t1_order", mlog[i], sent[i]);

    // All four requesting one-block messages: rotation from requester 0
    do_reset("rst1");
    clear_logs();
    for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push_msg(k, 1);
    drive_inputs();
    run_idle(200);
    for (int i = 0; i < 8; i++) chk("t2_rr", glog[i], i % N);
    for (int i = 1; i < 8; i++) chk("t2_norepeat", glog[i] != glog[i-1], 1);
    for (int i = 0; i < 8; i++) chk("t2_cnt", rclog[i], 1);

    // Requester 2 mid-message while 1 (then 1 and 3) begin requesting
    clear_logs();
    push_msg(2, 4);
    drive_inputs();
    wait_model(1, 1, 20);
    push_msg(1, 2);
    run_idle(100);
    chk("t3a_g0", glog[0], 2);
    chk("t3a_g1", glog[1], 1);
    clear_logs();
    push_msg(2, 4);
    drive_inputs();
    wait_model(1, 1, 20);
    push_msg(1, 1);
    push_msg(3, 1);
    run_idle(100);
    chk("t3b_g0", glog[0], 2);
    chk("t3b_g1", glog[1], 3);
    chk("t3b_g2", glog[2], 1);

    // Core stalls five cycles mid-message; an early digest waits for WAIT_D
    clear_logs();
    dig_pend = 1; dig_val = GW'(rand_blk()); dig_delay = 0;
    push_msg(0, 6);
    drive_inputs();
    wait_model(1, 2, 20);
    core_stall = 5;
    run_idle(100);
    chk("t4_nblk", mlog.size(), 6);
    for (int i = 0; i < 6; i++) chk("t4_order", mlog[i], sent[i]);
    chk("t4_cnt", rclog[0], 6);

    // Returned digest held while requesters refuse it; no new grant meanwhile
    clear_logs();
    r_block = 1;
    push_msg(1, 2);
    drive_inputs();
    wait_model(3, 2, 30);
    push_msg(2, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_noret", rlog.size(), 0);
    r_block = 0;
    run_idle(100);
    chk("t5_rtid", rlog[0], 1);
    chk("t5_next", glog[1], 2);

    // Randomised traffic, backpressure and digest latency
    gap_pct = 20; core_pct = 25; r_pct = 30; dig_dly_max = 3;
    for (int m = 0; m < 40; m++) begin
      push_msg($urandom_range(N-1), $urandom_range(4, 1));
      repeat ($urandom_range(3)) tick();
    end
    run_idle(5000);
    gap_pct = 0; core_pct = 0; r_pct = 0; dig_dly_max = 0;

    // Reset after two blocks of a message; requesters 0 and 3 then contend
    clear_logs();
    push_msg(3, 4);
    drive_inputs();
    wait_model(1, 2, 30);
    for (int k = 0; k < N; k++) begin srcq[k].delete(); srcl[k].delete(); end
    push_msg(0, 1);
    push_msg(3, 1);
    do_reset("rst2");
    clear_logs();
    run_idle(100);
    chk("t7_g0", glog[0], 0);
    chk("t7_g1", glog[1], 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
